// File: rtl/instruction_fetch.sv
// Instruction fetch/decode sequencer: reads one byte per instruction, splits it into
// opcode/src/dest, and waits for the execution unit before fetching the next one.
module instruction_fetch (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    input  logic [7:0] mem_data,
    input  logic       mem_valid,
    output logic       ready,
    output logic [3:0] opcode,
    output logic [1:0] src,
    output logic [1:0] dest,
    input  logic       exec_done,
    input  logic       branch_load,
    input  logic [7:0] branch_target,
    output logic       halted,
    output logic [7:0] pc_out,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        FETCH1    = 3'd0,
        FETCH2    = 3'd1,
        DECODE    = 3'd2,
        WAIT_EXEC = 3'd3,
        STOP      = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic       run_q, run_d;

    // run_q holds the sequencer in FETCH1 for the first edge after reset release, so the
    // read request comes from registered state and first appears on that edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH1;
            pc_q    <= 8'h00;
            ir_q    <= 8'h00;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        run_d   = 1'b1;
        case (state_q)
            FETCH1: begin
                if (run_q) state_d = FETCH2;
            end
            FETCH2: begin
                if (mem_valid) begin
                    ir_d    = mem_data;
                    pc_d    = pc_q + 8'd1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = (ir_q[7:4] == 4'hF) ? STOP : WAIT_EXEC;
            end
            WAIT_EXEC: begin
                if (exec_done) begin
                    state_d = FETCH1;
                    if (branch_load) pc_d = branch_target;
                end
            end
            STOP: begin
                state_d = STOP;
            end
            default: begin
                state_d = FETCH1;
            end
        endcase
    end

    assign mem_rd    = run_q && ((state_q == FETCH1) || (state_q == FETCH2));
    assign ready     = (state_q == WAIT_EXEC);
    assign halted    = (state_q == STOP);
    assign mem_addr  = pc_q;
    assign pc_out    = pc_q;
    assign opcode    = ir_q[7:4];
    assign src       = ir_q[3:2];
    assign dest      = ir_q[1:0];
    assign state_dbg = state_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have one clock domain and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low; low forces the reset state immediately.
REQ-004 mem_addr  output  8  instruction address, equal to the PC while a memory read is outstanding.
REQ-005 mem_rd  output  1  memory read request.
REQ-006 mem_data  input  8  instruction byte; sampled only when mem_valid=1.
REQ-007 mem_valid  input  1  memory response strobe; the memory may return it 1 or more cycles after mem_rd.
REQ-008 ready  output  1  decoded instruction is valid for the execution unit.
REQ-009 opcode  output  4  IR[7:4].
REQ-010 src  output  2  IR[3:2].
REQ-011 dest  output  2  IR[1:0].
REQ-012 exec_done  input  1  execution unit has finished the current instruction.
REQ-013 branch_load  input  1  qualifies exec_done; redirects the PC.
REQ-014 branch_target  input  8  new PC, used when exec_done=1 and branch_load=1.
REQ-015 halted  output  1  the block is in STOP.
REQ-016 pc_out  output  8  current PC, for debug.

Function
REQ-017 The block SHALL use the states FETCH1, FETCH2, DECODE, WAIT_EXEC and STOP, with a 3-bit encoding.
REQ-018 FETCH1: mem_rd=1, mem_addr=PC; next state FETCH2 unconditionally.
REQ-019 FETCH2: mem_rd=1, mem_addr=PC.
- mem_valid=0: stay in FETCH2.
- mem_valid=1: IR<=mem_data, PC<=PC+1, go to DECODE.
REQ-020 PC increment SHALL wrap modulo 256 (8'hFF -> 8'h00).
REQ-021 DECODE: ready=0; if IR[7:4]==4'hF (HLT), go to STOP, otherwise go to WAIT_EXEC.
REQ-022 WAIT_EXEC: ready=1; opcode, src and dest are driven from IR and held stable.
REQ-023 In WAIT_EXEC, exec_done=1 SHALL cause a return to FETCH1 on the next edge.
- If branch_load=1 on that same cycle, PC<=branch_target.
- If branch_load=0, PC is unchanged.
REQ-024 branch_load SHALL be ignored in every state other than WAIT_EXEC, and whenever exec_done=0.
REQ-025 exec_done SHALL be ignored outside WAIT_EXEC.
REQ-026 Latency: with mem_valid returned on the first FETCH2 cycle, ready SHALL rise 3 cycles after entering FETCH1.
REQ-027 Steady-state throughput is therefore one instruction per 4 + (memory wait) + (execution) cycles.
REQ-028 mem_valid arriving in FETCH1, DECODE, WAIT_EXEC or STOP SHALL be ignored and SHALL NOT load IR.
REQ-029 STOP: halted=1, mem_rd=0, ready=0; the block leaves STOP only on reset.
REQ-030 opcode, src and dest SHALL be driven from IR in all states; only ready qualifies them.
REQ-031 All outputs except mem_rd, ready and halted SHALL be registered or derived directly from registered state.
REQ-032 mem_rd, ready and halted SHALL be decoded from state only, with no combinational input-to-output path.

Reset
REQ-033 Reset low SHALL set, asynchronously:
- state=FETCH1;
- PC=8'h00, IR=8'h00;
- ready=0, halted=0.
REQ-034 While reset is held low, mem_rd SHALL be forced to 0.
REQ-035 The first fetch after reset release SHALL be from address 8'h00, with mem_rd asserted on the first edge after release.
REQ-036 Reset asserted mid-fetch or mid-execution SHALL abandon the outstanding read; a later mem_valid SHALL be ignored until FETCH2 is entered again.

Verification
REQ-037 Basic fetch: reset release, mem_data=8'h1B with mem_valid in the first FETCH2 cycle -> 3 cycles later ready=1, opcode=4'h1, src=2'b10, dest=2'b11, pc_out=8'h01.
REQ-038 Memory wait: hold mem_valid=0 for 5 FETCH2 cycles -> state stays FETCH2, mem_rd=1, mem_addr=8'h00, ready=0 throughout; IR loads only when mem_valid=1.
REQ-039 Branch: in WAIT_EXEC, exec_done=1, branch_load=1, branch_target=8'h40 -> next cycle FETCH1 with mem_addr=8'h40. Repeat with branch_load=0 -> mem_addr=PC (sequential).
REQ-040 Wrap-around: PC=8'hFF, fetch completes -> pc_out=8'h00 after the IR load.
REQ-041 Halt: fetch 8'hF0 -> after DECODE, halted=1, ready=0, mem_rd=0; exec_done and mem_valid pulses cause no change; reset low -> FETCH1, PC=8'h00.
REQ-042 Reset mid-operation: reset low during FETCH2, mem_valid pulsed while in reset -> IR stays 8'h00; after release the fetch restarts at 8'h00.
